// File: rtl/dec_scan_seq_if.sv
// Control and decoder-drive signals of the dual 2-to-4 decoder scan sequencer.
interface dec_scan_seq_if;
  logic i_start;
  logic i_stop;
  logic i_mode;
  logic i_repeat;
  logic o_g1;
  logic o_g2;
  logic o_a1;
  logic o_b1;
  logic o_a2;
  logic o_b2;
  logic o_busy;
  logic o_step;
  logic o_done;

  modport master (
    output i_start, i_stop, i_mode, i_repeat,
    input  o_g1, o_g2, o_a1, o_b1, o_a2, o_b2, o_busy, o_step, o_done
  );

  modport slave (
    input  i_start, i_stop, i_mode, i_repeat,
    output o_g1, o_g2, o_a1, o_b1, o_a2, o_b2, o_busy, o_step, o_done
  );
endinterface

// File: rtl/dec_scan_seq.sv
// Scans the codes of a dual 2-to-4 decoder (sequential or parallel halves), DWELL drive + BLANK gap cycles per code.
// Outputs are registered: a start sampled at one edge drives code 0 after that edge; no backpressure, stop aborts at the next edge.
module dec_scan_seq #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dec_scan_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LD   = (BLANK > 0) ? 8'(BLANK - 1) : 8'd0;

  state_t     r_state, w_state;
  logic [2:0] r_idx,   w_idx;
  logic [7:0] r_cnt,   w_cnt;
  logic       r_mode,  w_mode;
  logic       r_rpt,   w_rpt;
  logic       r_g1,    w_g1;
  logic       r_g2,    w_g2;
  logic       r_a1,    w_a1;
  logic       r_b1,    w_b1;
  logic       r_a2,    w_a2;
  logic       r_b2,    w_b2;
  logic       r_busy,  w_busy;
  logic       r_step,  w_step;
  logic       r_done,  w_done;
  logic       w_adv;
  logic [2:0] w_last;

  assign w_last = r_mode ? 3'd3 : 3'd7;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_mode  = r_mode;
    w_rpt   = r_rpt;
    w_g1    = 1'b1;
    w_g2    = 1'b1;
    w_a1    = r_a1;
    w_b1    = r_b1;
    w_a2    = r_a2;
    w_b2    = r_b2;
    w_step  = 1'b0;
    w_done  = 1'b0;
    w_adv   = 1'b0;

    case (r_state)
      IDLE: begin
        // start together with stop is treated as no request
        if (bus.i_start && !bus.i_stop) begin
          w_state = DRIVE;
          w_idx   = 3'd0;
          w_cnt   = DWELL_LD;
          w_mode  = bus.i_mode;
          w_rpt   = bus.i_repeat;
          w_step  = 1'b1;
        end
      end
      DRIVE: begin
        if (bus.i_stop) begin
          w_state = IDLE;
        end else if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else if (BLANK > 0) begin
          w_state = GAP;
          w_cnt   = GAP_LD;
        end else begin
          w_adv = 1'b1;
        end
      end
      GAP: begin
        if (bus.i_stop) begin
          w_state = IDLE;
        end else if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else begin
          w_adv = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_adv) begin
      if (r_idx != w_last) begin
        w_state = DRIVE;
        w_idx   = r_idx + 3'd1;
        w_cnt   = DWELL_LD;
        w_step  = 1'b1;
      end else if (r_rpt) begin
        w_state = DRIVE;
        w_idx   = 3'd0;
        w_cnt   = DWELL_LD;
        w_step  = 1'b1;
      end else begin
        w_state = IDLE;
        w_done  = 1'b1;
      end
    end

    // Only the half being driven updates its selects; the other keeps its last code
    if (w_state == DRIVE) begin
      if (w_mode) begin
        w_g1         = 1'b0;
        w_g2         = 1'b0;
        {w_b1, w_a1} = w_idx[1:0];
        {w_b2, w_a2} = w_idx[1:0];
      end else if (!w_idx[2]) begin
        w_g1         = 1'b0;
        {w_b1, w_a1} = w_idx[1:0];
      end else begin
        w_g2         = 1'b0;
        {w_b2, w_a2} = w_idx[1:0];
      end
    end

    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
      r_mode  <= 1'b0;
      r_rpt   <= 1'b0;
      r_g1    <= 1'b1;
      r_g2    <= 1'b1;
      r_a1    <= 1'b0;
      r_b1    <= 1'b0;
      r_a2    <= 1'b0;
      r_b2    <= 1'b0;
      r_busy  <= 1'b0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
      r_rpt   <= w_rpt;
      r_g1    <= w_g1;
      r_g2    <= w_g2;
      r_a1    <= w_a1;
      r_b1    <= w_b1;
      r_a2    <= w_a2;
      r_b2    <= w_b2;
      r_busy  <= w_busy;
      r_step  <= w_step;
      r_done  <= w_done;
    end
  end

  assign bus.o_g1   = r_g1;
  assign bus.o_g2   = r_g2;
  assign bus.o_a1   = r_a1;
  assign bus.o_b1   = r_b1;
  assign bus.o_a2   = r_a2;
  assign bus.o_b2   = r_b2;
  assign bus.o_busy = r_busy;
  assign bus.o_step = r_step;
  assign bus.o_done = r_done;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: a per-cycle output scoreboard filled when a scan is requested, drained as the DUT runs.
module tb_dec_scan_seq;

  typedef logic [8:0] vec_t; // {g1,g2,b1,a1,b2,a2,busy,step,done}

  localparam vec_t RST_VEC = 9'b11_0000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t q[$];
  logic [3:0] m_sel [2]; // model of held selects {b1,a1,b2,a2} per DUT

  always #5 clk = ~clk;

  dec_scan_seq_if u_if0();
  dec_scan_seq_if u_if1();

  dec_scan_seq #(.DWELL(3), .BLANK(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  dec_scan_seq #(.DWELL(1), .BLANK(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input bit st, input bit sp, input bit md, input bit rp);
    if (s == 0) begin
      u_if0.i_start = st; u_if0.i_stop = sp; u_if0.i_mode = md; u_if0.i_repeat = rp;
    end else begin
      u_if1.i_start = st; u_if1.i_stop = sp; u_if1.i_mode = md; u_if1.i_repeat = rp;
    end
  endtask

  function automatic vec_t get_obs(input int s);
    if (s == 0)
      return {u_if0.o_g1, u_if0.o_g2, u_if0.o_b1, u_if0.o_a1, u_if0.o_b2, u_if0.o_a2,
              u_if0.o_busy, u_if0.o_step, u_if0.o_done};
    return {u_if1.o_g1, u_if1.o_g2, u_if1.o_b1, u_if1.o_a1, u_if1.o_b2, u_if1.o_a2,
            u_if1.o_busy, u_if1.o_step, u_if1.o_done};
  endfunction

  function automatic vec_t mk(input bit g1, input bit g2, input logic [3:0] sel,
                              input bit busy, input bit step, input bit done);
    return {g1, g2, sel, busy, step, done};
  endfunction

  // Reference scan: every cycle from the first drive cycle to one idle cycle after done
  task automatic push_scan(input int s, input int dw, input int bl, input bit md,
                           input bit rp, input int passes);
    int last;
    bit g1, g2;
    logic [1:0] code;
    last = md ? 3 : 7;
    for (int p = 0; p < passes; p++) begin
      for (int c = 0; c <= last; c++) begin
        code = 2'(c % 4);
        if (md) begin
          g1 = 1'b0; g2 = 1'b0; m_sel[s] = {code, code};
        end else if (c < 4) begin
          g1 = 1'b0; g2 = 1'b1; m_sel[s][3:2] = code;
        end else begin
          g1 = 1'b1; g2 = 1'b0; m_sel[s][1:0] = code;
        end
        for (int d = 0; d < dw; d++) q.push_back(mk(g1, g2, m_sel[s], 1'b1, d == 0, 1'b0));
        for (int d = 0; d < bl; d++) q.push_back(mk(1'b1, 1'b1, m_sel[s], 1'b1, 1'b0, 1'b0));
      end
    end
    if (!rp) begin
      q.push_back(mk(1'b1, 1'b1, m_sel[s], 1'b0, 1'b0, 1'b1));
      q.push_back(mk(1'b1, 1'b1, m_sel[s], 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic run_scan(input int s, input int dw, input int bl, input bit md, input bit rp,
                          input int passes, input int stop_at, input int poke_at,
                          input int rst_at, input int exp_busy, input string name);
    vec_t exp, obs;
    int   i, busy_cnt;
    bit   cur_md;
    q.delete();
    push_scan(s, dw, bl, md, rp, passes);
    cur_md = md;
    @(negedge clk);
    drive(s, 1'b1, 1'b0, md, rp);
    i = 0;
    busy_cnt = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      drive(s, 1'b0, 1'b0, cur_md, rp);
      obs = get_obs(s);
      exp = q.pop_front();
      check_eq($sformatf("%s c%0d", name, i), 32'(obs), 32'(exp));
      if (obs[2]) busy_cnt++;
      if (i == poke_at) begin
        cur_md = ~md;
        drive(s, 1'b1, 1'b0, cur_md, ~rp);
      end
      if (i == stop_at) begin
        drive(s, 1'b0, 1'b1, cur_md, rp);
        m_sel[s] = exp[6:3];
        q.delete();
        q.push_back(mk(1'b1, 1'b1, m_sel[s], 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 1'b1, m_sel[s], 1'b0, 1'b0, 1'b0));
      end
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq($sformatf("%s async_rst", name), 32'(get_obs(s)), 32'(RST_VEC));
        #1 rst_n = 1'b1;
        m_sel[0] = 4'd0;
        m_sel[1] = 4'd0;
        q.delete();
      end
      i++;
    end
    check_eq($sformatf("%s busy_len", name), 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    m_sel[0] = 4'd0;
    m_sel[1] = 4'd0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_eq("rst dut0", 32'(get_obs(0)), 32'(RST_VEC));
    check_eq("rst dut1", 32'(get_obs(1)), 32'(RST_VEC));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle after rst", 32'(get_obs(0)), 32'(RST_VEC));

    run_scan(0, 3, 1, 1'b0, 1'b0, 1, -1, -1, -1, 32, "seq");
    run_scan(0, 3, 1, 1'b1, 1'b0, 1, -1, -1, -1, 16, "par");
    // second parallel pass, idx 2, second drive cycle
    run_scan(0, 3, 1, 1'b1, 1'b1, 2, 25, -1, -1, 26, "rpt_stop");
    run_scan(1, 1, 0, 1'b0, 1'b0, 1, -1, -1, -1, 8, "nogap");
    run_scan(0, 3, 1, 1'b0, 1'b0, 1, -1, 6, -1, 32, "collide");

    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("start_stop idle", 32'(get_obs(0)), 32'(mk(1'b1, 1'b1, m_sel[0], 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("stop idle", 32'(get_obs(0)), 32'(mk(1'b1, 1'b1, m_sel[0], 1'b0, 1'b0, 1'b0)));

    run_scan(0, 3, 1, 1'b0, 1'b0, 1, -1, -1, 5, 6, "arst");
    @(negedge clk);
    check_eq("after arst", 32'(get_obs(0)), 32'(RST_VEC));
    run_scan(0, 3, 1, 1'b0, 1'b0, 1, -1, -1, -1, 32, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
